// File: rtl/func_dynamiciser.sv
// func_dynamiciser
//   Serialises a parallel function word onto a dual-rail (d1/d0) line, one
//   digit per digit period. Each digit is marked by a one-hot pulse on ps.
//   A halt input freezes the word on the current digit and blanks the outputs.
//
// Parameters
//   INSTR_BITS   : digit periods per serial word
//   INSTR_F_BITS : function bits carried in digits 0..INSTR_F_BITS-1
//                  (legal range 1 <= INSTR_F_BITS <= INSTR_BITS)
//
// Ports
//   clk   : clock; all state changes on its rising edge
//   rst   : synchronous active-high reset
//   f     : parallel function bits; f[0] goes out in digit 0
//   load  : transmit request; only accepted while ready=1
//   ready : high only in IDLE
//   dp    : digit-period advance strobe
//   ha    : halt; has priority over dp
//   ps    : one-hot digit pulse for the current digit (SEND only)
//   d1    : serial data, true rail
//   d0    : serial data, complement rail
//   busy  : high in SEND or HALT
//   done  : one-cycle pulse in the first IDLE cycle after a word completes
module func_dynamiciser #(
    parameter int INSTR_BITS   = 20,
    parameter int INSTR_F_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:INSTR_F_BITS-1] f,
    input  logic                  load,
    output logic                  ready,
    input  logic                  dp,
    input  logic                  ha,
    output logic [0:INSTR_BITS-1] ps,
    output logic                  d1,
    output logic                  d0,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = (INSTR_BITS > 1) ? $clog2(INSTR_BITS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(INSTR_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_next;
    logic [0:INSTR_F_BITS-1] word;
    logic [0:INSTR_F_BITS-1] word_next;
    logic                    done_q;
    logic                    done_next;

    // State register. Reset clears the word too, so an aborted word leaves
    // nothing behind and produces no done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            word   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            word   <= word_next;
            done_q <= done_next;
        end
    end

    // Next-state logic. The counter only moves on dp in SEND, so a halted
    // digit is re-presented on resume and needs its own dp to advance.
    // done is registered so it lands in the first IDLE cycle, which is also
    // a cycle where a new load is accepted (one-cycle gap between words).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        word_next  = word;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    word_next  = f;
                    cnt_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (ha) begin
                    state_next = HALT;
                end else if (dp) begin
                    if (cnt == LAST_DIGIT) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
            end
            HALT: begin
                if (!ha) begin
                    state_next = SEND;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only. Digits beyond the function
    // field carry a zero on the true rail.
    always_comb begin
        ps = '0;
        d1 = 1'b0;
        for (int i = 0; i < INSTR_BITS; i++) begin
            if (state == SEND && cnt == CW'(i)) begin
                ps[i] = 1'b1;
            end
        end
        for (int i = 0; i < INSTR_F_BITS; i++) begin
            if (state == SEND && cnt == CW'(i)) begin
                d1 = word[i];
            end
        end
    end

    assign d0    = (state == SEND) && !d1;
    assign ready = (state == IDLE);
    assign busy  = (state == SEND) || (state == HALT);
    assign done  = done_q;

endmodule
